// File: rtl/fir_ntap_pipe.sv
// Pipelined direct-form FIR: delay line, full-precision product stage, then a
// registered pairwise adder tree; runtime-writable signed coefficients.
module fir_ntap_pipe #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8,
    parameter int OUT_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     clear,
    input  logic                     coef_we,
    input  logic [3:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  data_out
);

    localparam int LOG2 = $clog2(TAPS);
    localparam int PW   = DATA_W + COEF_W;

    logic signed [DATA_W-1:0] dl_d [TAPS];
    logic signed [DATA_W-1:0] dl_q [TAPS];
    logic signed [COEF_W-1:0] h_d  [TAPS];
    logic signed [COEF_W-1:0] h_q  [TAPS];
    logic [LOG2:0]            tag_d;
    logic [LOG2:0]            tag_q;
    logic                     out_valid_d;
    logic                     out_valid_q;
    logic                     accept;

    // A sample is taken only when no flush is requested in the same cycle
    always_comb begin
        accept = in_valid & ~clear;
    end

    // Delay line: flush, shift on an accepted sample, otherwise hold
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            dl_d[k] = dl_q[k];
        end
        if (clear) begin
            for (int k = 0; k < TAPS; k++) begin
                dl_d[k] = '0;
            end
        end else if (accept) begin
            dl_d[0] = data_in;
            for (int k = 1; k < TAPS; k++) begin
                dl_d[k] = dl_q[k-1];
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                dl_d[k] = dl_q[k];
            end
        end
    end

    // Coefficient bank: out-of-range addresses never match any tap
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            if (coef_we && (32'(coef_addr) == k)) begin
                h_d[k] = coef_wdata;
            end else begin
                h_d[k] = h_q[k];
            end
        end
    end

    // Valid tags ride alongside the data; flush kills everything in flight
    always_comb begin
        tag_d       = tag_q;
        out_valid_d = out_valid_q;
        if (clear) begin
            tag_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            tag_d       = {tag_q[LOG2-1:0], accept};
            out_valid_d = tag_q[LOG2];
        end
    end

    // Delay line, coefficients and tag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                dl_q[k] <= '0;
                h_q[k]  <= (k == 0) ? COEF_W'(1'b1) : '0;
            end
            tag_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            dl_q        <= dl_d;
            h_q         <= h_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Level 0 holds the products; level lv is the lv-th adder level, one bit wider each
    for (genvar lv = 0; lv <= LOG2; lv++) begin : g_lvl
        localparam int N = TAPS >> lv;
        localparam int W = PW + lv;

        logic signed [W-1:0] sum_d [N];
        logic signed [W-1:0] sum_q [N];
        logic                load;

        // A stage only captures when its own sample arrives, so data_out holds between results
        assign load = tag_q[lv] & ~clear;

        if (lv == 0) begin : g_mul
            // Signed full-precision products of history and current coefficients
            always_comb begin
                for (int k = 0; k < N; k++) begin
                    if (load) begin
                        sum_d[k] = W'(dl_q[k]) * W'(h_q[k]);
                    end else begin
                        sum_d[k] = sum_q[k];
                    end
                end
            end
        end else begin : g_add
            // Pairwise sums of the previous level, sign-extended by one bit
            always_comb begin
                for (int k = 0; k < N; k++) begin
                    if (load) begin
                        sum_d[k] = W'(g_lvl[lv-1].sum_q[2*k]) + W'(g_lvl[lv-1].sum_q[2*k+1]);
                    end else begin
                        sum_d[k] = sum_q[k];
                    end
                end
            end
        end

        // Stage register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < N; k++) begin
                    sum_q[k] <= '0;
                end
            end else begin
                sum_q <= sum_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = g_lvl[LOG2].sum_q[0];

endmodule

// File: tb/tb_fir_ntap_pipe.sv
// Directed + random bench for fir_ntap_pipe against a convolution model with
// a queue of expected results tagged by their due cycle.
module tb_fir_ntap_pipe;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic signed [15:0]  data_in = 16'sd0;
    logic                clear = 1'b0;
    logic                coef_we = 1'b0;
    logic [3:0]          coef_addr = 4'd0;
    logic signed [15:0]  coef_wdata = 16'sd0;
    logic                out_valid;
    logic signed [34:0]  data_out;

    int tests = 0;
    int fails = 0;

    longint m_h [8];
    longint m_x [8];
    int     cyc = 0;
    int     pend_due [$];
    longint pend_y [$];
    longint last_y = 0;

    always #5 clk = ~clk;

    fir_ntap_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .clear      (clear),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .out_valid  (out_valid),
        .data_out   (data_out)
    );

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_h[i] = (i == 0) ? 64'sd1 : 64'sd0;
            m_x[i] = 64'sd0;
        end
        pend_due.delete();
        pend_y.delete();
        last_y = 64'sd0;
    endtask

    task automatic check(input string tag, input bit exp_v, input longint exp_y);
        logic signed [34:0] e;
        e = 35'(exp_y);
        tests++;
        assert (out_valid === exp_v) else begin
            fails++;
            $error("FAIL %s out_valid got %0b expected %0b (cycle %0d)", tag, out_valid, exp_v, cyc);
        end
        tests++;
        assert (data_out === e) else begin
            fails++;
            $error("FAIL %s data_out got %0d expected %0d (cycle %0d)", tag, data_out, e, cyc);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then check outputs
    task automatic step(input string tag, input bit v, input longint d, input bit clr,
                        input bit we, input int a, input longint w);
        bit     ev;
        longint y;
        in_valid   = v;
        data_in    = 16'(d);
        clear      = clr;
        coef_we    = we;
        coef_addr  = 4'(a);
        coef_wdata = 16'(w);
        @(posedge clk);
        cyc++;
        if (we && a < 8) m_h[a] = w;
        if (clr) begin
            for (int i = 0; i < 8; i++) m_x[i] = 64'sd0;
            pend_due.delete();
            pend_y.delete();
        end else if (v) begin
            for (int i = 7; i > 0; i--) m_x[i] = m_x[i-1];
            m_x[0] = d;
            y = 64'sd0;
            for (int i = 0; i < 8; i++) y += m_h[i] * m_x[i];
            pend_due.push_back(cyc + 4);
            pend_y.push_back(y);
        end
        #1;
        ev = 1'b0;
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            ev = 1'b1;
            last_y = pend_y.pop_front();
            void'(pend_due.pop_front());
        end
        check(tag, ev, last_y);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic wr(input string tag, input int a, input longint w);
        step(tag, 1'b0, 0, 1'b0, 1'b1, a, w);
    endtask

    task automatic sample(input string tag, input longint d);
        step(tag, 1'b1, d, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        longint hv [8];
        longint ex;

        model_reset();
        #12;
        check("reset", 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle("reset_idle", 2);

        // Pass-through after reset
        sample("pass", 100);
        for (int i = 0; i < 7; i++) sample("pass", 0);
        idle("pass", 5);

        // Coefficient load and impulse
        hv = '{1, 2, 2, 3, 0, 0, 0, -1};
        for (int k = 0; k < 8; k++) wr("coef_wr", k, hv[k]);
        sample("coef_imp", 10);
        for (int i = 0; i < 7; i++) sample("coef_imp", 0);
        idle("coef_imp", 5);

        // Most-negative extremes: 8 * 2^30 = 2^33
        for (int k = 0; k < 8; k++) wr("ext_wr", k, -32768);
        for (int i = 0; i < 8; i++) sample("ext_neg", -32768);
        idle("ext_neg", 5);
        tests++;
        assert (data_out === 35'sh2_0000_0000) else begin
            fails++;
            $error("FAIL ext_neg_final data_out got %0d expected 8589934592", data_out);
        end
        for (int k = 0; k < 8; k++) wr("ext_wr2", k, 32767);
        for (int i = 0; i < 8; i++) sample("ext_mix", -32768);
        idle("ext_mix", 5);
        ex = -64'sd8589672448;
        tests++;
        assert (data_out === 35'(ex)) else begin
            fails++;
            $error("FAIL ext_mix_final data_out got %0d expected %0d", data_out, ex);
        end

        // Gapped input with the same impulse response
        for (int k = 0; k < 8; k++) wr("gap_wr", k, hv[k]);
        step("gap_clr", 1'b0, 0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            sample("gap", (i == 0) ? 10 : 0);
            idle("gap", 1);
        end
        idle("gap", 5);

        // clear mid-flight, then clear colliding with in_valid
        for (int k = 0; k < 8; k++) wr("clr_wr", k, k + 1);
        step("clr0", 1'b0, 0, 1'b1, 1'b0, 0, 0);
        sample("clr_fly", 11);
        sample("clr_fly", -22);
        sample("clr_fly", 33);
        step("clr_mid", 1'b0, 0, 1'b1, 1'b0, 0, 0);
        idle("clr_quiet", 6);
        sample("clr_after", 5);
        idle("clr_after", 5);
        step("clr_coll", 1'b1, 7, 1'b1, 1'b0, 0, 0);
        idle("clr_coll", 6);

        // Write to h[0] on the edge that forms this sample's products
        sample("wr_fly", 3);
        wr("wr_fly", 0, 9);
        idle("wr_fly", 4);
        wr("addr9", 9, 77);
        sample("addr9", 4);
        idle("addr9", 5);

        // Randomised traffic with writes and occasional clears
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 2) != 0),
                 longint'(int'($urandom_range(0, 65535)) - 32768),
                 1'($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)),
                 longint'(int'($urandom_range(0, 65535)) - 32768));
        end
        idle("rand_drain", 5);

        // Reset pulse mid-stream restores pass-through
        sample("pre_rst", 1234);
        sample("pre_rst", -4321);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid", 1'b0, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_rel", 1'b0, 0);
        sample("post_rst", 42);
        idle("post_rst", 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
